// File: rtl/ps2_key_tracker_pkg.sv
// Shared definitions for the PS/2 key tracker: decoder states, scan-code
// constants and the key-index assignments used by the keymap.
package ps2_key_tracker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BAT_OK = 8'hAA;
    localparam logic [7:0] CODE_ACK    = 8'hFA;
    localparam logic [7:0] CODE_RESEND = 8'hFE;
    localparam logic [7:0] CODE_ECHO   = 8'hEE;

    localparam int KEY_IDX_W = 6;

    localparam int KEY_Q     = 0;
    localparam int KEY_W     = 1;
    localparam int KEY_E     = 2;
    localparam int KEY_R     = 3;
    localparam int KEY_T     = 4;
    localparam int KEY_Y     = 5;
    localparam int KEY_U     = 6;
    localparam int KEY_I     = 7;
    localparam int KEY_O     = 8;
    localparam int KEY_P     = 9;
    localparam int KEY_A     = 10;
    localparam int KEY_S     = 11;
    localparam int KEY_D     = 12;
    localparam int KEY_F     = 13;
    localparam int KEY_G     = 14;
    localparam int KEY_H     = 15;
    localparam int KEY_J     = 16;
    localparam int KEY_K     = 17;
    localparam int KEY_L     = 18;
    localparam int KEY_Z     = 19;
    localparam int KEY_X     = 20;
    localparam int KEY_C     = 21;
    localparam int KEY_V     = 22;
    localparam int KEY_SPACE = 23;
    localparam int KEY_ENTER = 24;
    localparam int KEY_UP    = 25;
    localparam int KEY_DOWN  = 26;
    localparam int KEY_LEFT  = 27;
    localparam int KEY_RIGHT = 28;

    // Controller/keyboard status bytes that never start a key code.
    function automatic logic is_ignored_code(input logic [7:0] code);
        return (code == CODE_BAT_OK) || (code == CODE_ACK) ||
               (code == CODE_RESEND) || (code == CODE_ECHO);
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code lookup: 9-bit {ext, code} to tracked-key index.
module ps2_keymap
    import ps2_key_tracker_pkg::*;
(
    input  logic [8:0]           scan,
    output logic [KEY_IDX_W-1:0] idx,
    output logic                 hit
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        idx = '0;
        hit = 1'b1;
        case (scan)
            9'h015:  idx = KEY_IDX_W'(KEY_Q);
            9'h01D:  idx = KEY_IDX_W'(KEY_W);
            9'h024:  idx = KEY_IDX_W'(KEY_E);
            9'h02D:  idx = KEY_IDX_W'(KEY_R);
            9'h02C:  idx = KEY_IDX_W'(KEY_T);
            9'h035:  idx = KEY_IDX_W'(KEY_Y);
            9'h03C:  idx = KEY_IDX_W'(KEY_U);
            9'h043:  idx = KEY_IDX_W'(KEY_I);
            9'h044:  idx = KEY_IDX_W'(KEY_O);
            9'h04D:  idx = KEY_IDX_W'(KEY_P);
            9'h01C:  idx = KEY_IDX_W'(KEY_A);
            9'h01B:  idx = KEY_IDX_W'(KEY_S);
            9'h023:  idx = KEY_IDX_W'(KEY_D);
            9'h02B:  idx = KEY_IDX_W'(KEY_F);
            9'h034:  idx = KEY_IDX_W'(KEY_G);
            9'h033:  idx = KEY_IDX_W'(KEY_H);
            9'h03B:  idx = KEY_IDX_W'(KEY_J);
            9'h042:  idx = KEY_IDX_W'(KEY_K);
            9'h04B:  idx = KEY_IDX_W'(KEY_L);
            9'h01A:  idx = KEY_IDX_W'(KEY_Z);
            9'h022:  idx = KEY_IDX_W'(KEY_X);
            9'h021:  idx = KEY_IDX_W'(KEY_C);
            9'h02A:  idx = KEY_IDX_W'(KEY_V);
            9'h029:  idx = KEY_IDX_W'(KEY_SPACE);
            9'h05A:  idx = KEY_IDX_W'(KEY_ENTER);
            9'h175:  idx = KEY_IDX_W'(KEY_UP);
            9'h172:  idx = KEY_IDX_W'(KEY_DOWN);
            9'h16B:  idx = KEY_IDX_W'(KEY_LEFT);
            9'h174:  idx = KEY_IDX_W'(KEY_RIGHT);
            default: hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 scan codes into per-key held levels and queues
// make/break events in a first-word fall-through FIFO.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter  int NUM_KEYS      = 29,
    parameter  int FIFO_DEPTH    = 8,
    parameter  int REPORT_REPEAT = 0,
    localparam int KEY_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                clear_all,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                any_key_down,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KEY_W-1:0]    evt_key,
    output logic                evt_pressed,
    output logic                evt_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    ps2_state_e           state_q, state_d;
    logic                 code_done, is_break, is_ext;
    logic [KEY_IDX_W-1:0] map_idx;
    logic                 map_hit, key_hit;
    logic [KEY_W-1:0]     key_idx;
    logic [NUM_KEYS-1:0]  key_state_q, key_state_d;
    logic                 any_down_q, any_down_d;
    logic                 push, push_pressed, push_ok, pop;
    logic                 fifo_empty, fifo_full;
    logic [PTR_W:0]       wr_q, wr_d, rd_q, rd_d;
    logic                 ovf_q, ovf_d;
    logic [KEY_W:0]       mem_q [FIFO_DEPTH];
    logic [KEY_W:0]       head;

    assign is_break = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    assign is_ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

    always_comb begin
        state_d   = state_q;
        code_done = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == CODE_BRK)      state_d = ST_BRK;
                    else if (rx_data == CODE_EXT) state_d = ST_EXT;
                    else if (!is_ignored_code(rx_data)) code_done = 1'b1;
                end
                ST_EXT: begin
                    if (rx_data == CODE_BRK) state_d = ST_EXT_BRK;
                    else begin
                        code_done = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    code_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            endcase
        end
        if (clear_all) begin
            state_d   = ST_IDLE;
            code_done = 1'b0;
        end
    end

    ps2_keymap u_keymap (
        .scan ({is_ext, rx_data}),
        .idx  (map_idx),
        .hit  (map_hit)
    );

    // Table entries beyond NUM_KEYS behave as unmapped codes.
    assign key_hit = code_done && map_hit && (int'(map_idx) < NUM_KEYS);
    assign key_idx = map_idx[KEY_W-1:0];

    always_comb begin
        key_state_d  = key_state_q;
        push         = 1'b0;
        push_pressed = 1'b0;
        if (clear_all) begin
            key_state_d = '0;
        end else if (key_hit) begin
            if (!is_break) begin
                push                 = !key_state_q[key_idx] || (REPORT_REPEAT != 0);
                push_pressed         = 1'b1;
                key_state_d[key_idx] = 1'b1;
            end else begin
                push                 = key_state_q[key_idx];
                key_state_d[key_idx] = 1'b0;
            end
        end
        any_down_d = |key_state_d;
    end

    // The extra pointer MSB separates full from empty when the low bits match.
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                        (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && evt_ready;
    assign push_ok    = push && (!fifo_full || pop);

    always_comb begin
        wr_d  = wr_q + {{PTR_W{1'b0}}, push_ok};
        rd_d  = rd_q + {{PTR_W{1'b0}}, pop};
        ovf_d = ovf_q || (push && fifo_full && !pop);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state_q     <= ST_IDLE;
            key_state_q <= '0;
            any_down_q  <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_state_q <= key_state_d;
            any_down_q  <= any_down_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: FIFO storage has no reset; the outputs are masked while empty instead.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) mem_q[wr_q[PTR_W-1:0]] <= {key_idx, push_pressed};
    end

    assign head         = mem_q[rd_q[PTR_W-1:0]];
    assign evt_valid    = !fifo_empty;
    assign evt_key      = evt_valid ? head[KEY_W:1] : '0;
    assign evt_pressed  = evt_valid && head[0];
    assign evt_overflow = ovf_q;
    assign key_state    = key_state_q;
    assign any_key_down = any_down_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus a random
// byte stream compared against a behavioural key/event model.
module tb_ps2_key_tracker;

    localparam int NK = 29;
    localparam int DEPTH = 8;
    localparam int KW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn, rx_valid, clear_all, evt_ready;
    logic [7:0]    rx_data;
    logic [NK-1:0] key_state, rep_key_state;
    logic          any_key_down, evt_valid, evt_pressed, evt_overflow;
    logic          rep_any_key_down, rep_evt_valid, rep_evt_pressed, rep_evt_overflow;
    logic [KW-1:0] evt_key, rep_evt_key;

    ps2_key_tracker #(.NUM_KEYS(NK), .FIFO_DEPTH(DEPTH), .REPORT_REPEAT(0)) dut (
        .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear_all(clear_all), .key_state(key_state), .any_key_down(any_key_down),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
        .evt_pressed(evt_pressed), .evt_overflow(evt_overflow)
    );

    ps2_key_tracker #(.NUM_KEYS(NK), .FIFO_DEPTH(DEPTH), .REPORT_REPEAT(1)) dut_rep (
        .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .clear_all(clear_all), .key_state(rep_key_state), .any_key_down(rep_any_key_down),
        .evt_valid(rep_evt_valid), .evt_ready(1'b1), .evt_key(rep_evt_key),
        .evt_pressed(rep_evt_pressed), .evt_overflow(rep_evt_overflow)
    );

    // Key list in index order: {ext, code}.
    logic [8:0] keymap_t [NK] = '{
        9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C, 9'h035, 9'h03C, 9'h043, 9'h044, 9'h04D,
        9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034, 9'h033, 9'h03B, 9'h042, 9'h04B, 9'h01A,
        9'h022, 9'h021, 9'h02A, 9'h029, 9'h05A, 9'h175, 9'h172, 9'h16B, 9'h174
    };
    logic [7:0] ign_t [4] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE};

    logic [NK-1:0] held_m;
    logic          m_ext, m_brk, m_ovf;
    logic [KW:0]   mq[$], got_q[$], exp_q[$];
    int            passed = 0, total = 0, rep_pops = 0;

    always @(negedge clk) if (resetn && rep_evt_valid) rep_pops++;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    function automatic void lookup(input logic [8:0] s, output logic hit, output logic [KW-1:0] idx);
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NK; i++)
            if (!hit && keymap_t[i] == s) begin hit = 1'b1; idx = KW'(i); end
    endfunction

    task automatic reset_model();
        held_m = '0; m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
        mq.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, output logic push, output logic [KW:0] ev);
        logic hit;
        logic [KW-1:0] idx;
        push = 1'b0;
        ev = '0;
        if (!m_ext && !m_brk && (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE})) return;
        if (b == 8'hF0 && !m_brk) begin m_brk = 1'b1; return; end
        if (b == 8'hE0 && !m_ext && !m_brk) begin m_ext = 1'b1; return; end
        lookup({m_ext, b}, hit, idx);
        if (hit) begin
            push = m_brk ? held_m[idx] : !held_m[idx];
            held_m[idx] = !m_brk;
            ev = {idx, !m_brk};
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // One clock: drive at negedge, advance the model, return at the next negedge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
        logic pop, push;
        logic [KW:0] ev;
        rx_valid = v; rx_data = d; evt_ready = rdy; clear_all = clr;
        pop = (mq.size() != 0) && rdy;
        if (pop) begin
            got_q.push_back({evt_key, evt_pressed});
            exp_q.push_back(mq[0]);
        end
        push = 1'b0;
        ev = '0;
        if (clr) begin held_m = '0; m_ext = 1'b0; m_brk = 1'b0; end
        else if (v) model_byte(d, push, ev);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(ev);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0; clear_all = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        reset_model();
        @(negedge clk);
        resetn = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; clear_all = 1'b0; evt_ready = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        total++; if (key_state !== '0 || any_key_down !== 1'b0)
            $display("FAIL rst_keys got %h/%b need 0/0", key_state, any_key_down); else passed++;
        total++; if (evt_valid !== 1'b0 || evt_overflow !== 1'b0)
            $display("FAIL rst_fifo got valid=%b ovf=%b need 0/0", evt_valid, evt_overflow); else passed++;
        resetn = 1'b1;
        @(negedge clk);
        total++; if (evt_key !== '0 || evt_pressed !== 1'b0 || evt_valid !== 1'b0)
            $display("FAIL rst_head got key=%0d pr=%b v=%b need 0/0/0", evt_key, evt_pressed, evt_valid); else passed++;
    endtask

    task automatic test_make_break();
        apply_reset();
        send(8'h15);
        total++; if (key_state[0] !== 1'b1 || any_key_down !== 1'b1 || evt_valid !== 1'b1)
            $display("FAIL mb_make got q=%b any=%b v=%b need 1/1/1", key_state[0], any_key_down, evt_valid); else passed++;
        send(8'hF0);
        total++; if (key_state[0] !== 1'b1)
            $display("FAIL mb_prefix got q=%b need 1", key_state[0]); else passed++;
        send(8'h15);
        total++; if (key_state !== '0 || any_key_down !== 1'b0)
            $display("FAIL mb_break got %h any=%b need 0/0", key_state, any_key_down); else passed++;
        drain();
        total++; if (got_q.size() != 2 || got_q[0] !== {5'd0, 1'b1} || got_q[1] !== {5'd0, 1'b0})
            $display("FAIL mb_events got n=%0d first=%h need n=2 {Q,1},{Q,0}", got_q.size(),
                     (got_q.size() != 0) ? got_q[0] : 6'h3F); else passed++;
    endtask

    task automatic test_extended();
        apply_reset();
        send(8'hE0);
        send(8'h75);
        total++; if (key_state[25] !== 1'b1 || evt_valid !== 1'b1)
            $display("FAIL ext_make got up=%b v=%b need 1/1", key_state[25], evt_valid); else passed++;
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        total++; if (key_state !== '0)
            $display("FAIL ext_break got %h need 0", key_state); else passed++;
        send(8'h75);
        total++; if (key_state !== '0)
            $display("FAIL ext_bare got %h need 0", key_state); else passed++;
        drain();
        total++; if (got_q.size() != 2 || got_q[0] !== {5'd25, 1'b1} || got_q[1] !== {5'd25, 1'b0})
            $display("FAIL ext_events got n=%0d need n=2 {UP,1},{UP,0}", got_q.size()); else passed++;
    endtask

    task automatic test_repeat();
        int c0;
        apply_reset();
        c0 = rep_pops;
        for (int i = 0; i < 5; i++) begin
            send(8'h1C);
            total++; if (key_state[10] !== 1'b1 || rep_key_state[10] !== 1'b1 || rep_any_key_down !== 1'b1)
                $display("FAIL rep_held[%0d] got %b/%b need 1/1", i, key_state[10], rep_key_state[10]); else passed++;
            total++; if (rep_evt_valid !== 1'b1 || rep_evt_key !== 5'd10 || rep_evt_pressed !== 1'b1)
                $display("FAIL rep_head[%0d] got v=%b key=%0d need v=1 key=10", i, rep_evt_valid, rep_evt_key); else passed++;
        end
        drain();
        total++; if (got_q.size() != 1 || got_q[0] !== {5'd10, 1'b1})
            $display("FAIL rep_filter got n=%0d need 1 event {A,1}", got_q.size()); else passed++;
        total++; if (rep_pops - c0 != 5 || rep_evt_overflow !== 1'b0)
            $display("FAIL rep_report got n=%0d ovf=%b need 5/0", rep_pops - c0, rep_evt_overflow); else passed++;
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(keymap_t[i][7:0]);
            total++; if (evt_overflow !== (i == DEPTH))
                $display("FAIL ovf_flag[%0d] got %b need %b", i, evt_overflow, i == DEPTH); else passed++;
        end
        total++; if (key_state !== NK'((1 << (DEPTH + 1)) - 1))
            $display("FAIL ovf_keys got %h need %h", key_state, (1 << (DEPTH + 1)) - 1); else passed++;
        drain();
        total++; if (got_q.size() != DEPTH)
            $display("FAIL ovf_count got %0d need %0d", got_q.size(), DEPTH); else passed++;
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== {KW'(i), 1'b1})
                $display("FAIL ovf_order[%0d] got %h need %h", i, got_q[i], {KW'(i), 1'b1}); else passed++;
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        total++; if (evt_overflow !== 1'b1)
            $display("FAIL ovf_sticky got %b need 1", evt_overflow); else passed++;
    endtask

    task automatic test_push_pop_full();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) begin
            send(keymap_t[i][7:0]);
            total++; if (evt_valid !== 1'b1 || evt_key !== 5'd0 || evt_pressed !== 1'b1)
                $display("FAIL ppf_stable[%0d] got v=%b key=%0d need 1/0", i, evt_valid, evt_key); else passed++;
        end
        cycle(1'b1, keymap_t[DEPTH][7:0], 1'b1, 1'b0);
        total++; if (evt_overflow !== 1'b0 || evt_key !== 5'd1)
            $display("FAIL ppf_swap got ovf=%b head=%0d need 0/1", evt_overflow, evt_key); else passed++;
        drain();
        total++; if (got_q.size() != DEPTH + 1)
            $display("FAIL ppf_count got %0d need %0d", got_q.size(), DEPTH + 1); else passed++;
        for (int i = 0; i < got_q.size(); i++) begin
            total++; if (got_q[i] !== {KW'(i), 1'b1})
                $display("FAIL ppf_order[%0d] got %h need %h", i, got_q[i], {KW'(i), 1'b1}); else passed++;
        end
    endtask

    task automatic test_reset_clear();
        apply_reset();
        send(8'hF0);
        resetn = 1'b0;
        reset_model();
        #2;
        total++; if (state_ok_in_reset() !== 1'b1)
            $display("FAIL rc_in_reset got keys=%h v=%b need 0/0", key_state, evt_valid); else passed++;
        @(negedge clk);
        resetn = 1'b1;
        send(8'h15);
        total++; if (key_state[0] !== 1'b1 || evt_pressed !== 1'b1 || evt_key !== 5'd0)
            $display("FAIL rc_make got q=%b pr=%b key=%0d need 1/1/0", key_state[0], evt_pressed, evt_key); else passed++;
        send(8'h1D);
        send(8'h24);
        total++; if (key_state !== 29'h7)
            $display("FAIL rc_three got %h need 7", key_state); else passed++;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (key_state !== '0 || any_key_down !== 1'b0 || evt_valid !== 1'b1)
            $display("FAIL rc_clear got %h any=%b v=%b need 0/0/1", key_state, any_key_down, evt_valid); else passed++;
        cycle(1'b1, 8'hF0, 1'b0, 1'b1);
        send(8'h15);
        total++; if (key_state !== 29'h1)
            $display("FAIL rc_priority got %h need 1", key_state); else passed++;
        drain();
        total++; if (got_q.size() != 4 || got_q[0] !== 6'b000001 || got_q[1] !== 6'b000011 ||
                     got_q[2] !== 6'b000101 || got_q[3] !== 6'b000001)
            $display("FAIL rc_events got n=%0d need {Q,1},{W,1},{E,1},{Q,1}", got_q.size()); else passed++;
    endtask

    function automatic logic state_ok_in_reset();
        return (key_state == '0) && !evt_valid && !any_key_down && !evt_overflow;
    endfunction

    task automatic test_random();
        logic [7:0] b;
        int bad = 0;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: b = keymap_t[$urandom_range(0, NK - 1)][7:0];
                5, 6:          b = 8'hF0;
                7:             b = 8'hE0;
                8:             b = ign_t[$urandom_range(0, 3)];
                default:       b = 8'($urandom);
            endcase
            cycle(1'($urandom_range(0, 1)), b, ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0));
            total++;
            if (key_state !== held_m || any_key_down !== (|held_m) ||
                evt_valid !== (mq.size() != 0) || evt_overflow !== m_ovf) begin
                if (bad < 5) $display("FAIL rnd_state[%0d] got keys=%h v=%b ovf=%b need keys=%h v=%b ovf=%b",
                                      n, key_state, evt_valid, evt_overflow, held_m, mq.size() != 0, m_ovf);
                bad++;
            end else passed++;
        end
        drain();
        total++; if (got_q.size() != exp_q.size())
            $display("FAIL rnd_count got %0d need %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i])
                $display("FAIL rnd_event[%0d] got %h need %h", i, got_q[i], exp_q[i]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_repeat();
        test_overflow();
        test_push_pop_full();
        test_reset_clear();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
